// File: rtl/snake_pkg.sv
// Shared constants and types for the snake playfield renderer.
package snake_pkg;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int GRID_CELLS = GRID_W * GRID_H;
    localparam int ADDR_W     = 11;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BODY  = 2'd1,
        CELL_HEAD  = 2'd2,
        CELL_FOOD  = 2'd3
    } cell_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Colours packed as {R,G,B}
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_WHITE  = 3'b111;

    // Row-major cell address, row stride 40 built from two shifts
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] cx, input logic [5:0] cy);
        logic [ADDR_W-1:0] y;
        y = {5'd0, cy};
        return (y << 5) + (y << 3) + {5'd0, cx};
    endfunction

endpackage

// File: rtl/snake_grid_renderer_if.sv
// Bus bundle between the VGA timing / game logic side and the renderer.
interface snake_grid_renderer_if;

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic       hs_in;
    logic       vs_in;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [1:0] wr_data;
    logic       clear_req;
    logic       busy;
    logic       HS;
    logic       VS;
    logic       R;
    logic       G;
    logic       B;

    modport master (
        output hcount, vcount, video_on, hs_in, vs_in,
        output wr_en, wr_x, wr_y, wr_data, clear_req,
        input  busy, HS, VS, R, G, B
    );

    modport slave (
        input  hcount, vcount, video_on, hs_in, vs_in,
        input  wr_en, wr_x, wr_y, wr_data, clear_req,
        output busy, HS, VS, R, G, B
    );

endinterface

// File: rtl/snake_grid_renderer_grid_ram.sv
// Simple dual-port playfield RAM: one write port, one registered read-first read port.
module grid_ram #(
    parameter int DEPTH  = 1200,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [1:0]        wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [1:0]        rd
);

    logic [1:0] mem [0:DEPTH-1];

    // Write and read on the same edge; the read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd <= mem[ra];
    end

endmodule

// File: rtl/snake_grid_renderer.sv
// Turns VGA pixel counters into playfield cell colours, three cycles deep,
// and owns the playfield RAM plus its full-grid clear sequencer.
module snake_grid_renderer
    import snake_pkg::*;
#(
    parameter int GRID_W      = snake_pkg::GRID_W,
    parameter int GRID_H      = snake_pkg::GRID_H,
    parameter int CELL_SHIFT  = 4,
    parameter int DRAW_BORDER = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    snake_grid_renderer_if.slave  bus
);

    localparam logic [9:0]        GW10     = 10'(GRID_W);
    localparam logic [9:0]        GH10     = 10'(GRID_H);
    localparam logic [5:0]        GW6      = 6'(GRID_W);
    localparam logic [4:0]        GH5      = 5'(GRID_H);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(GRID_W * GRID_H - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;

    logic [9:0]        hsh;
    logic [9:0]        vsh;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [1:0]        ram_wd;
    logic [1:0]        ram_rd;

    logic [ADDR_W-1:0] addr_p1;
    logic              vld_p1, vld_p2;
    logic              border_p1, border_p2;
    logic              hs_p1, hs_p2, vs_p1, vs_p2;
    logic [2:0]        rgb_p3;
    logic              hs_p3, vs_p3;

    function automatic logic [2:0] cell_colour(input logic [1:0] code);
        case (code)
            CELL_BODY: return COL_GREEN;
            CELL_HEAD: return COL_YELLOW;
            CELL_FOOD: return COL_RED;
            default:   return COL_BLACK;
        endcase
    endfunction

    // Pixel-to-cell coordinates and game-write decode
    always_comb begin
        hsh     = bus.hcount >> CELL_SHIFT;
        vsh     = bus.vcount >> CELL_SHIFT;
        wr_ok   = bus.wr_en && (bus.wr_x < GW6) && (bus.wr_y < GH5);
        wr_addr = cell_addr(bus.wr_x, {1'b0, bus.wr_y});
    end

    // Write-port arbitration: the clear sequencer owns the port while busy
    always_comb begin
        ram_we = 1'b0;
        ram_wa = wr_addr;
        ram_wd = bus.wr_data;
        if (state == ST_CLEAR) begin
            ram_we = 1'b1;
            ram_wa = clr_addr;
            ram_wd = CELL_EMPTY;
        end else if (wr_ok) begin
            ram_we = 1'b1;
        end
    end

    // Clear / run sequencer with registered busy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (bus.clear_req) begin
                        clr_addr <= '0;
                    end else if (clr_addr == CLR_LAST) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    if (bus.clear_req) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
            endcase
        end
    end

    grid_ram #(
        .DEPTH  (GRID_W * GRID_H),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra  (addr_p1),
        .rd  (ram_rd)
    );

    // ---- stage 1: cell address and visibility/border flags
    always_ff @(posedge clk) begin
        addr_p1   <= cell_addr(hsh[5:0], vsh[5:0]);
        border_p1 <= (hsh == 10'd0) || (hsh == GW10 - 10'd1) ||
                     (vsh == 10'd0) || (vsh == GH10 - 10'd1);
    end

    // Stage 1 control: valid and sync delay
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            vld_p1 <= bus.video_on && (hsh < GW10) && (vsh < GH10);
            hs_p1  <= bus.hs_in;
            vs_p1  <= bus.vs_in;
        end
    end

    // ---- stage 2: RAM read in flight, flags follow
    always_ff @(posedge clk) begin
        border_p2 <= border_p1;
    end

    // Stage 2 control: valid and sync delay
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    // ---- stage 3: colour map into output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_p3 <= COL_BLACK;
            hs_p3  <= 1'b0;
            vs_p3  <= 1'b0;
        end else begin
            hs_p3 <= hs_p2;
            vs_p3 <= vs_p2;
            if (!vld_p2) begin
                rgb_p3 <= COL_BLACK;
            end else if (border_p2 && (DRAW_BORDER != 0)) begin
                rgb_p3 <= COL_WHITE;
            end else begin
                rgb_p3 <= cell_colour(ram_rd);
            end
        end
    end

    assign bus.busy = busy;
    assign bus.HS   = hs_p3;
    assign bus.VS   = vs_p3;
    assign bus.R    = rgb_p3[2];
    assign bus.G    = rgb_p3[1];
    assign bus.B    = rgb_p3[0];

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Directed bench for snake_grid_renderer: clear timing, rendering, sync
// alignment, border/bounds, read-first collision and clear/reset restarts.
module tb_snake_grid_renderer;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    snake_grid_renderer_if bus_a ();
    snake_grid_renderer_if bus_b ();

    snake_grid_renderer dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    snake_grid_renderer #(.DRAW_BORDER(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rgb_a();
        return {29'd0, bus_a.R, bus_a.G, bus_a.B};
    endfunction

    // Hold a pixel on the inputs for three edges and sample the result
    task automatic render(input logic [9:0] h, input logic [9:0] v, input logic von, output int rgb);
        @(negedge clk);
        bus_a.hcount   = h;
        bus_a.vcount   = v;
        bus_a.video_on = von;
        repeat (3) @(posedge clk);
        #1 rgb = rgb_a();
        @(negedge clk);
        bus_a.video_on = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] x, input logic [4:0] y, input logic [1:0] d);
        @(negedge clk);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_x    = x;
        bus_a.wr_y    = y;
        bus_a.wr_data = d;
        @(negedge clk);
        bus_a.wr_en   = 1'b0;
    endtask

    // Counts edges from reset release until busy drops (bounded)
    task automatic busy_cycles(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1 n++;
            if (!bus_a.busy) break;
        end
    endtask

    initial begin
        int rgb;
        int n;

        reset_n = 1'b0;
        bus_a.hcount = '0; bus_a.vcount = '0; bus_a.video_on = 1'b0;
        bus_a.hs_in = 1'b0; bus_a.vs_in = 1'b0; bus_a.wr_en = 1'b0;
        bus_a.wr_x = '0; bus_a.wr_y = '0; bus_a.wr_data = '0; bus_a.clear_req = 1'b0;
        bus_b.hcount = '0; bus_b.vcount = '0; bus_b.video_on = 1'b0;
        bus_b.hs_in = 1'b0; bus_b.vs_in = 1'b0; bus_b.wr_en = 1'b0;
        bus_b.wr_x = '0; bus_b.wr_y = '0; bus_b.wr_data = '0; bus_b.clear_req = 1'b0;

        repeat (3) @(posedge clk);
        #1 check("reset_state", {26'd0, bus_a.busy, bus_a.HS, bus_a.VS, bus_a.R, bus_a.G, bus_a.B}, 32);
        @(negedge clk);
        reset_n = 1'b1;
        busy_cycles(n);
        check("busy_len", n, 1200);

        render(10'd165, 10'd165, 1'b1, rgb);
        check("cleared_cell", rgb, 0);

        // Head at (5,7)
        do_write(6'd5, 5'd7, 2'd2);
        render(10'd85, 10'd120, 1'b1, rgb);
        check("head_cell", rgb, 6);
        render(10'd96, 10'd120, 1'b1, rgb);
        check("next_cell", rgb, 0);
        render(10'd85, 10'd120, 1'b0, rgb);
        check("video_off", rgb, 0);

        // Sync alignment with video off
        @(negedge clk);
        bus_a.hs_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1 check($sformatf("hs_lat%0d", k), bus_a.HS, (k >= 3) ? 1 : 0);
        end
        @(negedge clk);
        bus_a.hs_in = 1'b0;
        bus_a.vs_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("hsvs_lat%0d", k), {bus_a.HS, bus_a.VS}, (k >= 3) ? 1 : 2);
        end
        check("sync_rgb", rgb_a(), 0);
        @(negedge clk);
        bus_a.vs_in = 1'b0;

        // Border and bounds
        render(10'd0, 10'd200, 1'b1, rgb);
        check("border_left", rgb, 7);
        render(10'd639, 10'd479, 1'b1, rgb);
        check("border_corner", rgb, 7);
        render(10'd700, 10'd100, 1'b1, rgb);
        check("off_grid", rgb, 0);
        do_write(6'd45, 5'd3, 2'd3);
        render(10'd85, 10'd48, 1'b1, rgb);
        check("oob_row3", rgb, 0);
        render(10'd85, 10'd64, 1'b1, rgb);
        check("oob_row4", rgb, 0);

        // Food at (0,0) on the borderless instance
        @(negedge clk);
        bus_b.wr_en = 1'b1; bus_b.wr_x = 6'd0; bus_b.wr_y = 5'd0; bus_b.wr_data = 2'd3;
        @(negedge clk);
        bus_b.wr_en = 1'b0; bus_b.hcount = 10'd0; bus_b.vcount = 10'd0; bus_b.video_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("noborder_food", {29'd0, bus_b.R, bus_b.G, bus_b.B}, 4);
        @(negedge clk);
        bus_b.video_on = 1'b0;

        // Read/write collision at (10,10): body first, food written under the read
        do_write(6'd10, 5'd10, 2'd1);
        render(10'd165, 10'd165, 1'b1, rgb);
        check("coll_before", rgb, 2);
        @(negedge clk);
        bus_a.hcount = 10'd165; bus_a.vcount = 10'd165; bus_a.video_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.video_on = 1'b0;
        bus_a.wr_en = 1'b1; bus_a.wr_x = 6'd10; bus_a.wr_y = 5'd10; bus_a.wr_data = 2'd3;
        @(posedge clk);
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        @(posedge clk);
        #1 check("coll_old", rgb_a(), 2);
        render(10'd165, 10'd165, 1'b1, rgb);
        check("coll_new", rgb, 4);

        // Clear mid-operation
        do_write(6'd2, 5'd2, 2'd1);
        do_write(6'd3, 5'd3, 2'd2);
        do_write(6'd4, 5'd4, 2'd3);
        do_write(6'd5, 5'd5, 2'd1);
        render(10'd68, 10'd68, 1'b1, rgb);
        check("fill_food", rgb, 4);
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_x = 6'd1; bus_a.wr_y = 5'd1; bus_a.wr_data = 2'd2;
        bus_a.clear_req = 1'b1;
        @(posedge clk);
        #1 check("busy_rise", bus_a.busy, 1);
        @(negedge clk);
        bus_a.wr_en = 1'b0; bus_a.clear_req = 1'b0;
        bus_a.hcount = 10'd20; bus_a.vcount = 10'd20; bus_a.video_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("clr_write_lands", rgb_a(), 6);
        @(negedge clk);
        bus_a.video_on = 1'b0;
        repeat (597) @(posedge clk);
        do_write(6'd6, 5'd6, 2'd3);
        n = 0;
        while (bus_a.busy && n < 1300) begin
            @(posedge clk);
            #1 n++;
        end
        check("clr_done", bus_a.busy, 0);
        for (int c = 1; c <= 6; c++) begin
            render(10'(c * 16 + 4), 10'(c * 16 + 4), 1'b1, rgb);
            check($sformatf("cleared_%0d", c), rgb, 0);
        end

        // Reset at clear count 600 restarts the whole clear
        @(negedge clk);
        bus_a.clear_req = 1'b1;
        bus_a.hcount = 10'd0; bus_a.vcount = 10'd0; bus_a.video_on = 1'b1; bus_a.hs_in = 1'b1;
        @(negedge clk);
        bus_a.clear_req = 1'b0;
        repeat (599) @(posedge clk);
        #1 check("pre_reset", {28'd0, bus_a.R, bus_a.G, bus_a.B, bus_a.HS}, 15);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 check("reset_flush", {26'd0, bus_a.busy, bus_a.HS, bus_a.VS, bus_a.R, bus_a.G, bus_a.B}, 32);
        @(negedge clk);
        reset_n = 1'b1;
        bus_a.video_on = 1'b0; bus_a.hs_in = 1'b0;
        busy_cycles(n);
        check("busy_len_restart", n, 1200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
